ib_pkt_ram_writer: RTL and testbench
====================================

Name: ib_pkt_ram_writer

Overview:
- Inbound packet-capture stage feeding the inbound RAM controller (IbRamCtlr).
- Accepts an AXI-Stream packet from the PCIe DMA inbound path and writes it beat-by-beat into the inbound packet RAM.
- On completion, raises the tlast/enableUseRam pair consumed by IbRamCtlr, then holds the buffer until the consumer releases it.
- Single-buffer: at most one packet resident at a time.

Parameters:
DATA_W, 64, stream/RAM data width in bits (multiple of 8)
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W beats
KEEP_W, DATA_W/8, byte-enable width (derived, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_tdata  in  DATA_W  inbound stream data
s_tkeep  in  KEEP_W  byte enables; all-ones on non-last beats, low-aligned contiguous on last beat
s_tvalid  in  1  stream valid
s_tlast  in  1  last beat of packet
s_tready  out  1  stream ready
ram_we  out  1  RAM write strobe
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
pkt_tlast  out  1  one-cycle packet-complete pulse to IbRamCtlr tlast
enable_use_ram  out  1  buffer holds a valid packet; drives IbRamCtlr enableUseRam
pkt_len_beats  out  ADDR_W+1  beats in held packet (1..DEPTH)
pkt_len_bytes  out  ADDR_W+4  bytes in held packet
ram_release  in  1  consumer done with buffer (driven from IbRamCtlr RamValid path)
overflow_err  out  1  one-cycle pulse when an oversize packet is dropped

Behaviour:
- Handshake: beat accepted when s_tvalid & s_tready. tvalid gaps are allowed at any point.
- Reset values: state IDLE; s_tready=0 during reset, then 1 in IDLE; ram_we=0, ram_waddr=0, ram_wdata=0, pkt_tlast=0, enable_use_ram=0, pkt_len_*=0, overflow_err=0. Internal beat_cnt (ADDR_W+1 bits) = 0.
- RAM write is registered. A beat accepted at edge N gives ram_we=1 during cycle N+1, with ram_waddr = beat_cnt before increment and ram_wdata = s_tdata.
- Reset mid-operation: everything returns to reset values; any partial or held packet is discarded.
- States:
  - IDLE: s_tready=1; beat_cnt=0.
    - Accepted beat with tlast -> COMMIT.
    - Accepted beat without tlast -> FILL.
  - FILL: s_tready=1; each accepted beat is written and beat_cnt increments.
    - Accepted tlast with beat_cnt<DEPTH -> latch lengths, then COMMIT.
    - Accepted beat while beat_cnt==DEPTH -> beat not written, overflow_err pulses, go to DROP; or straight to IDLE if that beat had tlast.
  - COMMIT: exactly one cycle; s_tready=0; the final ram_we occurs here. Next state HOLD.
  - HOLD: s_tready=0; enable_use_ram=1.
    - pkt_tlast=1 only in the first HOLD cycle, so IbRamCtlr sees tlast & enableUseRam together exactly once.
    - ram_release=1 -> IDLE next cycle, enable_use_ram=0. Release is honoured even in the first HOLD cycle.
    - ram_release outside HOLD is ignored.
  - DROP: s_tready=1; beats discarded with no ram_we. Accepted tlast -> IDLE. No pkt_tlast and no enable_use_ram.
- Latency: last beat accepted at edge N -> final write cycle N+1 -> pkt_tlast/enable_use_ram high at cycle N+2.
- Lengths:
  - pkt_len_beats = beat count including the last beat.
  - pkt_len_bytes = (pkt_len_beats-1)*KEEP_W + popcount(s_tkeep of last beat).
  - Latched on the last beat; held stable in COMMIT and HOLD; zeroed on entry to IDLE.
  - Last-beat tkeep == 0 counts as 0 bytes for that beat; not an error.
- Exactly DEPTH beats fits (addresses 0..DEPTH-1). DEPTH+1 beats overflows. No address wrap ever occurs.
- Consumer contract: data at addresses 0..pkt_len_beats-1 is stable from the pkt_tlast cycle until ram_release.

Test Plan:
1. Single beat, tkeep=0xFF, tlast=1 at edge 0 -> ram_we@addr0 in cycle 1; pkt_tlast pulse cycle 2; len_beats=1, len_bytes=8.
2. 4 beats D0..D3, last tkeep=0x0F, with one tvalid gap -> writes addr 0..3 in order; len_beats=4, len_bytes=28; single pkt_tlast pulse.
3. Hold backpressure: after test 2, present the next packet with ram_release low for 20 cycles -> s_tready=0 throughout; release asserted -> IDLE next cycle; enable_use_ram falls; next packet writes from addr 0.
4. Overflow, ADDR_W=3: 10-beat packet -> 8 writes (addr 0..7); overflow_err pulses on beat 9; beat 10 drained; no pkt_tlast; next 2-beat packet captured normally.
5. Exactly DEPTH (8) beats -> no overflow; len_beats=8; last write at addr 7.
6. rst_n asserted mid-FILL and again mid-HOLD -> all outputs return to reset values immediately; subsequent packet captured from addr 0.

Source files
------------

// File: rtl/ib_pkt_ram_writer.sv
// ib_pkt_ram_writer: captures one inbound AXI-Stream packet into the packet RAM and hands it to IbRamCtlr
module ib_pkt_ram_writer #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 8,
   localparam int KEEP_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic [KEEP_W-1:0] s_tkeep,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              pkt_tlast,
   output logic              enable_use_ram,
   output logic [ADDR_W:0]   pkt_len_beats,
   output logic [ADDR_W+3:0] pkt_len_bytes,
   input  logic              ram_release,
   output logic              overflow_err
);
   typedef enum logic [2:0] {IDLE, FILL, COMMIT, HOLD, DROP} state_t;
   localparam logic [ADDR_W:0] ONE = 1;
   state_t state, nstate;
   logic [ADDR_W:0] beat_cnt;
   logic acc, full, wr, ovf;
   function automatic logic [ADDR_W+3:0] popcount(input logic [KEEP_W-1:0] k);
      logic [ADDR_W+3:0] c;
      c = '0;
      for (int i = 0; i < KEEP_W; i++) c = c + (ADDR_W+4)'(k[i]);
      return c;
   endfunction
   assign acc = s_tvalid & s_tready;
   // beat_cnt reaches DEPTH only once the buffer is completely full
   assign full = beat_cnt[ADDR_W];
   assign wr = acc & ((state == IDLE) | (state == FILL)) & ~full;
   assign ovf = acc & (state == FILL) & full;
   assign enable_use_ram = (state == HOLD);
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nstate;
   // next-state decode
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    nstate = acc ? (s_tlast ? COMMIT : FILL) : IDLE;
         FILL:    nstate = ovf ? (s_tlast ? IDLE : DROP) : (acc & s_tlast) ? COMMIT : FILL;
         COMMIT:  nstate = HOLD;
         HOLD:    nstate = ram_release ? IDLE : HOLD;
         DROP:    nstate = (acc & s_tlast) ? IDLE : DROP;
         default: nstate = IDLE;
      endcase
   end
   // registered RAM write port, ready, completion pulse and packet lengths
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s_tready      <= 1'b0;
         ram_we        <= 1'b0;
         ram_waddr     <= '0;
         ram_wdata     <= '0;
         pkt_tlast     <= 1'b0;
         overflow_err  <= 1'b0;
         beat_cnt      <= '0;
         pkt_len_beats <= '0;
         pkt_len_bytes <= '0;
      end else begin
         s_tready     <= (nstate == IDLE) | (nstate == FILL) | (nstate == DROP);
         ram_we       <= wr;
         pkt_tlast    <= (state == COMMIT);
         overflow_err <= ovf;
         beat_cnt     <= (nstate == IDLE) ? '0 : wr ? beat_cnt + ONE : beat_cnt;
         if (wr) begin
            ram_waddr <= beat_cnt[ADDR_W-1:0];
            ram_wdata <= s_tdata;
         end
         if (nstate == IDLE) begin
            pkt_len_beats <= '0;
            pkt_len_bytes <= '0;
         end else if (wr & s_tlast) begin
            pkt_len_beats <= beat_cnt + ONE;
            pkt_len_bytes <= (ADDR_W+4)'(beat_cnt) * (ADDR_W+4)'(KEEP_W) + popcount(s_tkeep);
         end
      end
endmodule

// File: tb/tb_ib_pkt_ram_writer.sv
// tb_ib_pkt_ram_writer: directed packets against a packet-level reference model plus literal spot checks
module tb_ib_pkt_ram_writer;
   localparam int DW = 64;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [7:0] s_tkeep = '0;
   logic s_tvalid = 1'b0;
   logic s_tlast = 1'b0;
   logic ram_release = 1'b0;
   logic s_tready, ram_we, pkt_tlast, enable_use_ram, overflow_err;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW:0] pkt_len_beats;
   logic [AW+3:0] pkt_len_bytes;
   int n_chk = 0;
   int n_pass = 0;
   int wr_cnt = 0;
   int tl_cnt = 0;
   int ov_cnt = 0;
   logic [DW-1:0] mem [DEPTH];

   ib_pkt_ram_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tready(s_tready), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .pkt_tlast(pkt_tlast), .enable_use_ram(enable_use_ram),
      .pkt_len_beats(pkt_len_beats), .pkt_len_bytes(pkt_len_bytes), .ram_release(ram_release),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: tracks beats of the current packet and whether a packet is held.
   // A packet of n beats fits when n <= DEPTH; beat index DEPTH is the one that flags overflow.
   logic m_rdy, m_held, m_we, m_ovf;
   int m_n, m_age;
   logic [AW:0] m_lb;
   logic [AW+3:0] m_lB;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   wire m_acc = s_tvalid & m_rdy;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_rdy <= 1'b0; m_held <= 1'b0; m_we <= 1'b0; m_ovf <= 1'b0;
         m_n <= 0; m_age <= 0; m_lb <= '0; m_lB <= '0; m_addr <= '0; m_data <= '0;
      end else begin
         m_we <= m_acc && m_n < DEPTH;
         m_ovf <= m_acc && m_n == DEPTH;
         m_addr <= AW'(m_n);
         m_data <= s_tdata;
         if (m_held) begin
            m_age <= m_age + 1;
            if (m_age >= 1 && ram_release) begin
               m_held <= 1'b0; m_rdy <= 1'b1; m_lb <= '0; m_lB <= '0; m_age <= 0;
            end
         end else if (m_acc && s_tlast) begin
            m_n <= 0;
            if (m_n < DEPTH) begin
               m_held <= 1'b1; m_age <= 0; m_rdy <= 1'b0;
               m_lb <= (AW+1)'(m_n + 1);
               m_lB <= (AW+4)'(m_n * 8 + $countones(s_tkeep));
            end else m_rdy <= 1'b1;
         end else begin
            if (m_acc) m_n <= m_n + 1;
            m_rdy <= 1'b1;
         end
      end

   always @(negedge clk) begin
      chk("s_tready", s_tready, m_rdy);
      chk("ram_we", ram_we, m_we);
      if (m_we) begin
         chk("ram_waddr", ram_waddr, m_addr);
         chk("ram_wdata", ram_wdata, m_data);
      end
      chk("pkt_tlast", pkt_tlast, m_held && m_age == 1);
      chk("enable_use_ram", enable_use_ram, m_held && m_age >= 1);
      chk("pkt_len_beats", pkt_len_beats, m_lb);
      chk("pkt_len_bytes", pkt_len_bytes, m_lB);
      chk("overflow_err", overflow_err, m_ovf);
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (pkt_tlast) tl_cnt <= tl_cnt + 1;
      if (overflow_err) ov_cnt <= ov_cnt + 1;
   end

   task automatic reset_chk(input string nm);
      chk({nm, "_rdy"}, s_tready, 0);
      chk({nm, "_we"}, ram_we, 0);
      chk({nm, "_addr"}, ram_waddr, 0);
      chk({nm, "_data"}, ram_wdata, 0);
      chk({nm, "_tlast"}, pkt_tlast, 0);
      chk({nm, "_eur"}, enable_use_ram, 0);
      chk({nm, "_beats"}, pkt_len_beats, 0);
      chk({nm, "_bytes"}, pkt_len_bytes, 0);
      chk({nm, "_ovf"}, overflow_err, 0);
   endtask

   task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
      n = 0;
      while (!s_tready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n == 64) chk("ready_timeout", s_tready, 1);
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic pkt(input int nb, input logic [7:0] lastk, input logic [63:0] base);
      for (int i = 0; i < nb; i++) beat(base + 64'(i), (i == nb - 1) ? lastk : 8'hFF, i == nb - 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_buf();
      ram_release = 1'b1;
      @(negedge clk);
      ram_release = 1'b0;
   endtask

   initial begin
      int w0, o0, t0;
      #1 rst_n = 1'b0;
      #1 reset_chk("rst0");
      idle(2);
      rst_n = 1'b1;
      // single-beat packet
      beat(64'hA5A5_0000_0000_0001, 8'hFF, 1'b1);
      chk("t1_we", ram_we, 1);
      chk("t1_addr", ram_waddr, 0);
      chk("t1_data", ram_wdata, 64'hA5A5_0000_0000_0001);
      chk("t1_rdy_commit", s_tready, 0);
      idle(1);
      chk("t1_tlast", pkt_tlast, 1);
      chk("t1_eur", enable_use_ram, 1);
      chk("t1_beats", pkt_len_beats, 1);
      chk("t1_bytes", pkt_len_bytes, 8);
      release_buf();
      chk("t1_eur_off", enable_use_ram, 0);
      chk("t1_rdy_back", s_tready, 1);
      chk("t1_beats_clr", pkt_len_beats, 0);
      // four beats with a tvalid gap
      beat(64'hD0, 8'hFF, 1'b0);
      idle(2);
      beat(64'hD1, 8'hFF, 1'b0);
      beat(64'hD2, 8'hFF, 1'b0);
      beat(64'hD3, 8'h0F, 1'b1);
      idle(1);
      chk("t2_tlast", pkt_tlast, 1);
      chk("t2_beats", pkt_len_beats, 4);
      chk("t2_bytes", pkt_len_bytes, 28);
      for (int i = 0; i < 4; i++) chk("t2_mem", mem[i], 64'hD0 + 64'(i));
      // held buffer backpressures the next packet
      s_tvalid = 1'b1; s_tdata = 64'hE0; s_tkeep = 8'hFF; s_tlast = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("t3_hold_rdy", s_tready, 0);
      end
      chk("t3_eur_held", enable_use_ram, 1);
      chk("t3_bytes_held", pkt_len_bytes, 28);
      release_buf();
      chk("t3_eur_off", enable_use_ram, 0);
      chk("t3_rdy_on", s_tready, 1);
      idle(1);
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("t3_we", ram_we, 1);
      chk("t3_addr", ram_waddr, 0);
      chk("t3_data", ram_wdata, 64'hE0);
      idle(1);
      chk("t3_tlast", pkt_tlast, 1);
      release_buf();
      // oversize packet is dropped, next packet captured normally
      idle(1);
      w0 = wr_cnt; o0 = ov_cnt; t0 = tl_cnt;
      pkt(10, 8'hFF, 64'hB000);
      idle(3);
      chk("t4_writes", wr_cnt - w0, 8);
      chk("t4_ovf", ov_cnt - o0, 1);
      chk("t4_no_tlast", tl_cnt - t0, 0);
      chk("t4_mem7", mem[7], 64'hB007);
      chk("t4_eur", enable_use_ram, 0);
      pkt(2, 8'h03, 64'hC000);
      chk("t4b_addr", ram_waddr, 1);
      idle(1);
      chk("t4b_tlast", pkt_tlast, 1);
      chk("t4b_beats", pkt_len_beats, 2);
      chk("t4b_bytes", pkt_len_bytes, 10);
      release_buf();
      // exactly DEPTH beats fits
      o0 = ov_cnt;
      pkt(8, 8'hFF, 64'hD000);
      chk("t5_we", ram_we, 1);
      chk("t5_addr", ram_waddr, 7);
      idle(1);
      chk("t5_beats", pkt_len_beats, 8);
      chk("t5_bytes", pkt_len_bytes, 64);
      chk("t5_ovf", ov_cnt - o0, 0);
      release_buf();
      // release outside HOLD is ignored
      ram_release = 1'b1;
      idle(2);
      ram_release = 1'b0;
      chk("t5_rdy_idle", s_tready, 1);
      // reset mid-FILL
      beat(64'hE1, 8'hFF, 1'b0);
      beat(64'hE2, 8'hFF, 1'b0);
      #3 rst_n = 1'b0;
      #1 reset_chk("rst_fill");
      @(negedge clk);
      rst_n = 1'b1;
      pkt(3, 8'hFF, 64'hF000);
      idle(1);
      chk("t6_eur", enable_use_ram, 1);
      chk("t6_beats", pkt_len_beats, 3);
      // reset mid-HOLD
      #3 rst_n = 1'b0;
      #1 reset_chk("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      beat(64'hF100, 8'h01, 1'b1);
      chk("t6_we", ram_we, 1);
      chk("t6_addr", ram_waddr, 0);
      chk("t6_data", ram_wdata, 64'hF100);
      idle(1);
      chk("t6_tlast", pkt_tlast, 1);
      chk("t6_bytes", pkt_len_bytes, 1);
      release_buf();
      idle(2);
      chk("tlast_total", tl_cnt, 7);
      chk("ovf_total", ov_cnt, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end
endmodule
